// File: rtl/scu_bac_clk_gate_mgr_if.sv
// Register-bank / client-side signal bundle for the SCU BAC clock gate manager.
// master: register bank and clients driving requests; slave: the gate manager.
interface scu_bac_clk_gate_mgr_if #(
    parameter int P_CLIENT_NUM = 32,
    parameter int P_GROUP_NUM  = 2,
    parameter int P_IDLE_CNT_W = 8,
    parameter int P_SRST_W     = 4
);
    logic                    dft_scan_en_i;
    logic [P_CLIENT_NUM-1:0] clk_en_set_i;
    logic [P_CLIENT_NUM-1:0] clk_en_clr_i;
    logic [P_CLIENT_NUM-1:0] auto_gate_en_i;
    logic [P_CLIENT_NUM-1:0] client_idle_i;
    logic [P_IDLE_CNT_W-1:0] idle_thresh_i;
    logic [P_CLIENT_NUM-1:0] srst_req_i;
    logic [P_SRST_W-1:0]     srst_len_i;
    logic [P_CLIENT_NUM-1:0] clk_en_sta_o;
    logic [P_CLIENT_NUM-1:0] clk_active_o;
    logic [P_CLIENT_NUM-1:0] wake_evt_o;
    logic [P_CLIENT_NUM-1:0] srst_n_o;
    logic [P_CLIENT_NUM-1:0] srst_busy_o;
    logic [P_GROUP_NUM-1:0]  gated_clk_o;

    modport master (
        output dft_scan_en_i, clk_en_set_i, clk_en_clr_i, auto_gate_en_i, client_idle_i,
               idle_thresh_i, srst_req_i, srst_len_i,
        input  clk_en_sta_o, clk_active_o, wake_evt_o, srst_n_o, srst_busy_o, gated_clk_o
    );

    modport slave (
        input  dft_scan_en_i, clk_en_set_i, clk_en_clr_i, auto_gate_en_i, client_idle_i,
               idle_thresh_i, srst_req_i, srst_len_i,
        output clk_en_sta_o, clk_active_o, wake_evt_o, srst_n_o, srst_busy_o, gated_clk_o
    );
endinterface

// File: rtl/scu_bac_clk_gate_mgr.sv
// Per-client clock enable, idle auto-gating and counted soft reset for SCU BAC clients.
// Clients map onto P_GROUP_NUM gated clocks (client i -> group i % P_GROUP_NUM).
//
// state        | meaning
// ST_OFF       | SW enable cleared, clock not requested
// ST_RUN       | clock requested, client busy or auto-gating disabled
// ST_IDLE_WAIT | client idle, counting hysteresis before gating
// ST_GATED     | idle long enough, clock released until client wakes
module scu_bac_clk_gate_mgr #(
    parameter int                      P_CLIENT_NUM = 32,
    parameter int                      P_GROUP_NUM  = 2,
    parameter int                      P_IDLE_CNT_W = 8,
    parameter int                      P_SRST_W     = 4,
    parameter logic [P_CLIENT_NUM-1:0] P_EN_RST_VAL = '1
) (
    input logic                     kernel_clk_i,
    input logic                     synced_kernel_reset_s,
    scu_bac_clk_gate_mgr_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RUN       = 2'd1,
        ST_IDLE_WAIT = 2'd2,
        ST_GATED     = 2'd3
    } state_e;

    state_e                  state_q    [P_CLIENT_NUM];
    state_e                  state_d    [P_CLIENT_NUM];
    logic [P_IDLE_CNT_W-1:0] idle_cnt_q [P_CLIENT_NUM];
    logic [P_IDLE_CNT_W-1:0] idle_cnt_d [P_CLIENT_NUM];
    logic [P_SRST_W-1:0]     srst_cnt_q [P_CLIENT_NUM];
    logic [P_SRST_W-1:0]     srst_cnt_d [P_CLIENT_NUM];

    logic [P_CLIENT_NUM-1:0] enable_q, enable_d;
    logic [P_CLIENT_NUM-1:0] busy_q, busy_d;
    logic [P_CLIENT_NUM-1:0] wake_q, wake_d;
    logic [P_CLIENT_NUM-1:0] clk_active_q, clk_active_d;
    logic [P_GROUP_NUM-1:0]  gated_clk;

    // SW enable: set wins over clear when both are asserted.
    assign enable_d = bus.clk_en_set_i | (enable_q & ~bus.clk_en_clr_i);

    // Next-state, hysteresis counters, soft-reset down-counters and registered outputs.
    always_comb begin
        for (int i = 0; i < P_CLIENT_NUM; i++) begin
            state_d[i]    = state_q[i];
            idle_cnt_d[i] = idle_cnt_q[i];
            srst_cnt_d[i] = srst_cnt_q[i];
            busy_d[i]     = busy_q[i];
            wake_d[i]     = 1'b0;

            if (!enable_d[i]) begin
                state_d[i] = ST_OFF;
            end else begin
                case (state_q[i])
                    ST_OFF: state_d[i] = ST_RUN;
                    ST_RUN: begin
                        if (bus.auto_gate_en_i[i] && bus.client_idle_i[i]) begin
                            state_d[i]    = ST_IDLE_WAIT;
                            idle_cnt_d[i] = '0;
                        end
                    end
                    ST_IDLE_WAIT: begin
                        if (!(bus.auto_gate_en_i[i] && bus.client_idle_i[i])) begin
                            state_d[i] = ST_RUN;
                        end else if (idle_cnt_q[i] >= bus.idle_thresh_i) begin
                            state_d[i] = ST_GATED;
                        end else if (idle_cnt_q[i] != {P_IDLE_CNT_W{1'b1}}) begin
                            idle_cnt_d[i] = idle_cnt_q[i] + 1'b1;
                        end
                    end
                    ST_GATED: begin
                        if (!(bus.auto_gate_en_i[i] && bus.client_idle_i[i])) begin
                            state_d[i] = ST_RUN;
                            wake_d[i]  = 1'b1;
                        end
                    end
                    default: state_d[i] = ST_OFF;
                endcase
            end

            // Length is captured at request time; terminal count 1 ends the pulse.
            if (busy_q[i]) begin
                if (srst_cnt_q[i] == P_SRST_W'(1)) begin
                    busy_d[i]     = 1'b0;
                    srst_cnt_d[i] = '0;
                end else begin
                    srst_cnt_d[i] = srst_cnt_q[i] - 1'b1;
                end
            end else if (bus.srst_req_i[i]) begin
                busy_d[i]     = 1'b1;
                srst_cnt_d[i] = (bus.srst_len_i == '0) ? P_SRST_W'(1) : bus.srst_len_i;
            end

            clk_active_d[i] = (state_d[i] == ST_RUN) || (state_d[i] == ST_IDLE_WAIT) || busy_d[i];
        end
    end

    // State and counter registers; reset state follows the enable reset value.
    always_ff @(posedge kernel_clk_i or negedge synced_kernel_reset_s) begin
        if (!synced_kernel_reset_s) begin
            enable_q     <= P_EN_RST_VAL;
            busy_q       <= '0;
            wake_q       <= '0;
            clk_active_q <= P_EN_RST_VAL;
            for (int i = 0; i < P_CLIENT_NUM; i++) begin
                state_q[i]    <= P_EN_RST_VAL[i] ? ST_RUN : ST_OFF;
                idle_cnt_q[i] <= '0;
                srst_cnt_q[i] <= '0;
            end
        end else begin
            enable_q     <= enable_d;
            busy_q       <= busy_d;
            wake_q       <= wake_d;
            clk_active_q <= clk_active_d;
            for (int i = 0; i < P_CLIENT_NUM; i++) begin
                state_q[i]    <= state_d[i];
                idle_cnt_q[i] <= idle_cnt_d[i];
                srst_cnt_q[i] <= srst_cnt_d[i];
            end
        end
    end

    // One ICG per group: latch-based enable so the gated clock never glitches.
    for (genvar g = 0; g < P_GROUP_NUM; g++) begin : g_icg
        logic grp_en;
        logic en_lat;

        // OR of the registered clock requests of every client in this group.
        always_comb begin
            grp_en = 1'b0;
            for (int i = g; i < P_CLIENT_NUM; i += P_GROUP_NUM) begin
                grp_en = grp_en | clk_active_q[i];
            end
        end

        // Enable latch transparent while the clock is low; scan forces it open.
        always_latch begin
            if (!kernel_clk_i) en_lat = grp_en | bus.dft_scan_en_i;
        end

        assign gated_clk[g] = kernel_clk_i & en_lat;
    end

    assign bus.clk_en_sta_o = enable_q;
    assign bus.clk_active_o = clk_active_q;
    assign bus.wake_evt_o   = wake_q;
    assign bus.srst_busy_o  = busy_q;
    assign bus.srst_n_o     = ~busy_q;
    assign bus.gated_clk_o  = gated_clk;

endmodule

// File: tb/tb_scu_bac_clk_gate_mgr.sv
// Testbench for scu_bac_clk_gate_mgr: directed scenarios plus a randomized run,
// all compared against a run-length based reference model.
module tb_scu_bac_clk_gate_mgr;
    localparam int N  = 32;
    localparam int G  = 2;
    localparam int IW = 8;
    localparam int SW = 4;
    localparam logic [N-1:0] ALL1 = {N{1'b1}};
    localparam logic [N-1:0] ODD  = 32'hAAAA_AAAA;

    logic kernel_clk_i = 1'b0;
    logic synced_kernel_reset_s = 1'b0;

    scu_bac_clk_gate_mgr_if #(.P_CLIENT_NUM(N), .P_GROUP_NUM(G), .P_IDLE_CNT_W(IW), .P_SRST_W(SW)) bus ();

    scu_bac_clk_gate_mgr #(
        .P_CLIENT_NUM(N), .P_GROUP_NUM(G), .P_IDLE_CNT_W(IW), .P_SRST_W(SW), .P_EN_RST_VAL(ALL1)
    ) dut (
        .kernel_clk_i          (kernel_clk_i),
        .synced_kernel_reset_s (synced_kernel_reset_s),
        .bus                   (bus)
    );

    always #5 kernel_clk_i = ~kernel_clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    wire gclk0 = bus.gated_clk_o[0];
    wire gclk1 = bus.gated_clk_o[1];
    int gcnt0 = 0;
    int gcnt1 = 0;
    always @(posedge gclk0) gcnt0 = gcnt0 + 1;
    always @(posedge gclk1) gcnt1 = gcnt1 + 1;

    // Reference model: consecutive qualifying idle cycles, sticky gated flag,
    // remaining soft-reset low cycles.
    logic [N-1:0] m_en, m_off, m_gated, m_wake;
    int m_run  [N];
    int m_left [N];

    task automatic model_reset();
        m_en    = ALL1;
        m_off   = '0;
        m_gated = '0;
        m_wake  = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i]  = 0;
            m_left[i] = 0;
        end
    endtask

    function automatic logic [N-1:0] m_active();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (!m_off[i] && !m_gated[i]) || (m_left[i] > 0);
        return v;
    endfunction

    function automatic logic [N-1:0] m_busy();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_left[i] > 0);
        return v;
    endfunction

    // Advance the model with the inputs currently applied, then let one clock edge pass.
    task automatic cyc();
        logic [N-1:0] en_new;
        int thr;
        thr = int'(bus.idle_thresh_i);
        en_new = bus.clk_en_set_i | (m_en & ~bus.clk_en_clr_i);
        for (int i = 0; i < N; i++) begin
            bit ok;
            ok = bus.auto_gate_en_i[i] & bus.client_idle_i[i];
            m_wake[i] = 1'b0;
            if (!en_new[i]) begin
                m_off[i] = 1'b1; m_gated[i] = 1'b0; m_run[i] = 0;
            end else if (m_off[i]) begin
                m_off[i] = 1'b0; m_run[i] = 0;
            end else if (ok) begin
                if (m_run[i] < 100000) m_run[i]++;
                if (m_run[i] >= thr + 2) m_gated[i] = 1'b1;
            end else begin
                m_wake[i] = m_gated[i]; m_gated[i] = 1'b0; m_run[i] = 0;
            end
            if (m_left[i] > 0) m_left[i]--;
            else if (bus.srst_req_i[i]) m_left[i] = (bus.srst_len_i == 0) ? 1 : int'(bus.srst_len_i);
        end
        m_en = en_new;
        @(negedge kernel_clk_i);
    endtask

    task automatic clear_inputs();
        bus.dft_scan_en_i  = 1'b0;
        bus.clk_en_set_i   = '0;
        bus.clk_en_clr_i   = '0;
        bus.auto_gate_en_i = '0;
        bus.client_idle_i  = '0;
        bus.idle_thresh_i  = '0;
        bus.srst_req_i     = '0;
        bus.srst_len_i     = '0;
    endtask

    task automatic test_reset();
        @(negedge kernel_clk_i);
        @(negedge kernel_clk_i);
        n_checks++; if (bus.clk_en_sta_o !== ALL1) begin n_fail++; $display("FAIL reset_sta: got %h expected %h", bus.clk_en_sta_o, ALL1); end
        n_checks++; if (bus.clk_active_o !== ALL1) begin n_fail++; $display("FAIL reset_active: got %h expected %h", bus.clk_active_o, ALL1); end
        n_checks++; if (bus.srst_n_o !== ALL1) begin n_fail++; $display("FAIL reset_srst_n: got %h expected %h", bus.srst_n_o, ALL1); end
        n_checks++; if (bus.srst_busy_o !== '0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", bus.srst_busy_o); end
        n_checks++; if (bus.wake_evt_o !== '0) begin n_fail++; $display("FAIL reset_wake: got %h expected 0", bus.wake_evt_o); end
        synced_kernel_reset_s = 1'b1;
        model_reset();
    endtask

    task automatic test_sw_enable();
        bus.clk_en_clr_i[3] = 1'b1;
        cyc();
        bus.clk_en_clr_i[3] = 1'b0;
        n_checks++; if (bus.clk_en_sta_o[3] !== 1'b0) begin n_fail++; $display("FAIL clr_sta3: got %b expected 0", bus.clk_en_sta_o[3]); end
        n_checks++; if (bus.clk_active_o[3] !== 1'b0) begin n_fail++; $display("FAIL clr_active3: got %b expected 0", bus.clk_active_o[3]); end
        n_checks++; if (bus.clk_en_sta_o !== m_en) begin n_fail++; $display("FAIL clr_sta_vec: got %h expected %h", bus.clk_en_sta_o, m_en); end
        bus.clk_en_set_i[3] = 1'b1;
        bus.clk_en_clr_i[3] = 1'b1;
        cyc();
        n_checks++; if (bus.clk_en_sta_o[3] !== 1'b1) begin n_fail++; $display("FAIL setclr_from_off: got %b expected 1", bus.clk_en_sta_o[3]); end
        cyc();
        bus.clk_en_set_i[3] = 1'b0;
        bus.clk_en_clr_i[3] = 1'b0;
        n_checks++; if (bus.clk_en_sta_o[3] !== 1'b1) begin n_fail++; $display("FAIL setclr_stays: got %b expected 1", bus.clk_en_sta_o[3]); end
        n_checks++; if (bus.clk_active_o !== m_active()) begin n_fail++; $display("FAIL setclr_active: got %h expected %h", bus.clk_active_o, m_active()); end
    endtask

    task automatic test_auto_gate();
        logic exp;
        bus.idle_thresh_i     = 8'd4;
        bus.auto_gate_en_i[0] = 1'b1;
        bus.client_idle_i[0]  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            exp = (k < 6);
            n_checks++; if (bus.clk_active_o[0] !== exp) begin n_fail++; $display("FAIL gate_active0 cycle %0d: got %b expected %b", k, bus.clk_active_o[0], exp); end
            n_checks++; if (bus.clk_active_o !== m_active()) begin n_fail++; $display("FAIL gate_model cycle %0d: got %h expected %h", k, bus.clk_active_o, m_active()); end
        end
        bus.client_idle_i[0] = 1'b0;
        cyc();
        n_checks++; if (bus.clk_active_o[0] !== 1'b1) begin n_fail++; $display("FAIL wake_active0: got %b expected 1", bus.clk_active_o[0]); end
        n_checks++; if (bus.wake_evt_o !== m_wake) begin n_fail++; $display("FAIL wake_evt: got %h expected %h", bus.wake_evt_o, m_wake); end
        n_checks++; if (bus.wake_evt_o[0] !== 1'b1) begin n_fail++; $display("FAIL wake_evt0: got %b expected 1", bus.wake_evt_o[0]); end
        cyc();
        n_checks++; if (bus.wake_evt_o[0] !== 1'b0) begin n_fail++; $display("FAIL wake_evt0_one_cycle: got %b expected 0", bus.wake_evt_o[0]); end
        bus.auto_gate_en_i[0] = 1'b0;
        cyc();
    endtask

    task automatic test_group_gate();
        int c0, c1;
        bus.idle_thresh_i  = 8'd1;
        bus.auto_gate_en_i = ODD;
        bus.client_idle_i  = ODD;
        repeat (5) cyc();
        n_checks++; if ((bus.clk_active_o & ODD) !== '0) begin n_fail++; $display("FAIL grp_odd_gated: got %h expected 0", bus.clk_active_o & ODD); end
        n_checks++; if (bus.clk_active_o !== m_active()) begin n_fail++; $display("FAIL grp_model: got %h expected %h", bus.clk_active_o, m_active()); end
        c0 = gcnt0; c1 = gcnt1;
        repeat (4) cyc();
        n_checks++; if (gcnt1 - c1 !== 0) begin n_fail++; $display("FAIL grp1_stopped: got %0d edges expected 0", gcnt1 - c1); end
        n_checks++; if (gcnt0 - c0 !== 4) begin n_fail++; $display("FAIL grp0_running: got %0d edges expected 4", gcnt0 - c0); end
        bus.dft_scan_en_i = 1'b1;
        c1 = gcnt1;
        repeat (4) cyc();
        n_checks++; if (gcnt1 - c1 !== 4) begin n_fail++; $display("FAIL grp1_scan: got %0d edges expected 4", gcnt1 - c1); end
        bus.dft_scan_en_i = 1'b0;
        bus.client_idle_i = '0;
        cyc();
        n_checks++; if (bus.wake_evt_o !== ODD) begin n_fail++; $display("FAIL grp_wake: got %h expected %h", bus.wake_evt_o, ODD); end
        n_checks++; if (bus.clk_active_o !== m_active()) begin n_fail++; $display("FAIL grp_wake_active: got %h expected %h", bus.clk_active_o, m_active()); end
        bus.auto_gate_en_i = '0;
        cyc();
    endtask

    task automatic test_soft_reset();
        logic exp_n;
        bus.idle_thresh_i     = 8'd0;
        bus.auto_gate_en_i[2] = 1'b1;
        bus.client_idle_i[2]  = 1'b1;
        repeat (3) cyc();
        n_checks++; if (bus.clk_active_o[2] !== 1'b0) begin n_fail++; $display("FAIL srst_pre_gated: got %b expected 0", bus.clk_active_o[2]); end
        bus.srst_len_i    = 4'd5;
        bus.srst_req_i[2] = 1'b1;
        cyc();
        bus.srst_req_i[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin
                bus.srst_req_i[2] = (k == 3);
                cyc();
            end
            exp_n = (k > 5);
            n_checks++; if (bus.srst_n_o[2] !== exp_n) begin n_fail++; $display("FAIL srst_n2 cycle %0d: got %b expected %b", k, bus.srst_n_o[2], exp_n); end
            n_checks++; if (bus.clk_active_o[2] !== !exp_n) begin n_fail++; $display("FAIL srst_active2 cycle %0d: got %b expected %b", k, bus.clk_active_o[2], !exp_n); end
            n_checks++; if (bus.srst_busy_o !== m_busy()) begin n_fail++; $display("FAIL srst_busy cycle %0d: got %h expected %h", k, bus.srst_busy_o, m_busy()); end
        end
        bus.srst_req_i[2] = 1'b0;
        bus.srst_len_i    = 4'd0;
        bus.srst_req_i[2] = 1'b1;
        cyc();
        bus.srst_req_i[2] = 1'b0;
        n_checks++; if (bus.srst_n_o[2] !== 1'b0) begin n_fail++; $display("FAIL srst_len0_low: got %b expected 0", bus.srst_n_o[2]); end
        cyc();
        n_checks++; if (bus.srst_n_o[2] !== 1'b1) begin n_fail++; $display("FAIL srst_len0_end: got %b expected 1", bus.srst_n_o[2]); end
        n_checks++; if (bus.clk_active_o !== m_active()) begin n_fail++; $display("FAIL srst_end_active: got %h expected %h", bus.clk_active_o, m_active()); end
        bus.auto_gate_en_i[2] = 1'b0;
        bus.client_idle_i[2]  = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        bus.idle_thresh_i = 8'd3;
        for (int c = 0; c < 400; c++) begin
            bus.clk_en_set_i   = $urandom & $urandom & $urandom;
            bus.clk_en_clr_i   = $urandom & $urandom & $urandom;
            bus.auto_gate_en_i = bus.auto_gate_en_i ^ ($urandom & $urandom & $urandom & $urandom);
            bus.client_idle_i  = bus.client_idle_i ^ ($urandom & $urandom & $urandom);
            bus.srst_req_i     = $urandom & $urandom & $urandom & $urandom;
            bus.srst_len_i     = 4'($urandom_range(0, 15));
            cyc();
            n_checks++; if (bus.clk_en_sta_o !== m_en) begin n_fail++; $display("FAIL rnd_sta cycle %0d: got %h expected %h", c, bus.clk_en_sta_o, m_en); end
            n_checks++; if (bus.clk_active_o !== m_active()) begin n_fail++; $display("FAIL rnd_active cycle %0d: got %h expected %h", c, bus.clk_active_o, m_active()); end
            n_checks++; if (bus.wake_evt_o !== m_wake) begin n_fail++; $display("FAIL rnd_wake cycle %0d: got %h expected %h", c, bus.wake_evt_o, m_wake); end
            n_checks++; if (bus.srst_busy_o !== m_busy()) begin n_fail++; $display("FAIL rnd_busy cycle %0d: got %h expected %h", c, bus.srst_busy_o, m_busy()); end
            n_checks++; if (bus.srst_n_o !== ~m_busy()) begin n_fail++; $display("FAIL rnd_srst_n cycle %0d: got %h expected %h", c, bus.srst_n_o, ~m_busy()); end
        end
        clear_inputs();
        repeat (20) cyc();
    endtask

    task automatic test_async_reset();
        bus.idle_thresh_i     = 8'd20;
        bus.auto_gate_en_i[5] = 1'b1;
        bus.client_idle_i[5]  = 1'b1;
        bus.clk_en_clr_i[9]   = 1'b1;
        cyc();
        bus.clk_en_clr_i[9] = 1'b0;
        repeat (2) cyc();
        bus.srst_len_i    = 4'd7;
        bus.srst_req_i[6] = 1'b1;
        cyc();
        bus.srst_req_i[6] = 1'b0;
        cyc();
        n_checks++; if (bus.srst_busy_o !== m_busy()) begin n_fail++; $display("FAIL arst_pre_busy: got %h expected %h", bus.srst_busy_o, m_busy()); end
        #2 synced_kernel_reset_s = 1'b0;
        #1;
        n_checks++; if (bus.clk_en_sta_o !== ALL1) begin n_fail++; $display("FAIL arst_sta: got %h expected %h", bus.clk_en_sta_o, ALL1); end
        n_checks++; if (bus.clk_active_o !== ALL1) begin n_fail++; $display("FAIL arst_active: got %h expected %h", bus.clk_active_o, ALL1); end
        n_checks++; if (bus.srst_n_o !== ALL1) begin n_fail++; $display("FAIL arst_srst_n: got %h expected %h", bus.srst_n_o, ALL1); end
        n_checks++; if (bus.srst_busy_o !== '0) begin n_fail++; $display("FAIL arst_busy: got %h expected 0", bus.srst_busy_o); end
        n_checks++; if (bus.wake_evt_o !== '0) begin n_fail++; $display("FAIL arst_wake: got %h expected 0", bus.wake_evt_o); end
        clear_inputs();
        @(negedge kernel_clk_i);
        @(negedge kernel_clk_i);
        synced_kernel_reset_s = 1'b1;
        model_reset();
        cyc();
        n_checks++; if (bus.clk_active_o !== m_active()) begin n_fail++; $display("FAIL arst_after_active: got %h expected %h", bus.clk_active_o, m_active()); end
        n_checks++; if (bus.srst_n_o !== ALL1) begin n_fail++; $display("FAIL arst_after_srst_n: got %h expected %h", bus.srst_n_o, ALL1); end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_sw_enable();
        test_auto_gate();
        test_group_gate();
        test_soft_reset();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
